audio_adc_deserializer: RTL and testbench
=========================================

Name: audio_adc_deserializer

Overview:
- Upstream front end for the audio_interface ADC pins (ADCDAT, ADCLRCK, BCLK) driven by the codec in I2S slave-clock mode.
- Synchronizes the codec serial lines into the system clock domain and deserializes left and right words.
- Buffers complete stereo pairs in a small FIFO.
- Presents pairs on a valid/ready stream consumed by the NIOS II audio input path.

Parameters:
- SAMPLE_W, 16, bits per channel word captured (MSB first); range 8..32
- FIFO_DEPTH, 4, stereo pairs buffered; power of 2, at least 2
- SYNC_STAGES, 2, flip-flop stages on each asynchronous codec input; at least 2

Ports:
- clk_clk  input  1  system clock; must be at least 4x BCLK frequency
- reset_reset_n  input  1  asynchronous active-low reset
- audio_interface_ADCDAT  input  1  codec serial data, asynchronous
- audio_interface_ADCLRCK  input  1  codec word select, asynchronous; 0 = left, 1 = right
- audio_interface_BCLK  input  1  codec bit clock, asynchronous
- out_left  output  SAMPLE_W  left sample, two's complement
- out_right  output  SAMPLE_W  right sample, two's complement
- out_valid  output  1  head-of-FIFO pair available
- out_ready  input  1  consumer accepts the pair
- clear_flags  input  1  single-cycle pulse; clears the sticky flags
- overflow  output  1  sticky; a pair was dropped because the FIFO was full
- frame_err  output  1  sticky; a channel word ended short of SAMPLE_W bits

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - All outputs are 0: out_left, out_right, out_valid, overflow, frame_err.
  - FIFO is emptied and the FSM enters SYNC.
  - Asserting reset mid-word discards all partial and buffered data.
- Input synchronization: ADCDAT, ADCLRCK and BCLK each pass through SYNC_STAGES flip-flops.
  - A BCLK rise is detected as synced-BCLK 0 then 1 on consecutive clk_clk cycles.
  - All capture decisions are made only on a detected BCLK rise, using the synced LRCK and DATA values.
  - An LRCK edge means the value sampled at this BCLK rise differs from the value sampled at the previous BCLK rise.
- FSM states:
  - SYNC: ignore data. On an LRCK 1->0 edge (start of left) go to DELAY with chan = L.
  - DELAY: skip exactly one BCLK rise (the I2S one-bit delay), then go to SHIFT with bit count 0.
  - SHIFT: on each BCLK rise, shift DATA into the channel word MSB-first and increment the count.
    - When the count reaches SAMPLE_W, latch the word into the L or R holding register and go to HOLD.
  - HOLD: ignore further bits until an LRCK edge. On the edge, toggle chan and go to DELAY.
- LRCK edge arriving while in SHIFT (short word):
  - The word received so far is left-aligned and the missing LSBs are zero.
  - The word is latched as complete and frame_err is set.
  - chan toggles and the FSM goes to DELAY.
- Pair assembly:
  - A pair is emitted only when an R word completes after an L word in the same frame.
  - An R word completing with no pending L word is discarded; this covers startup and post-reset.
- Push latency: the pair is written to the FIFO on the clk_clk cycle after the R word latches. out_valid rises on the following cycle.
- FIFO / stream:
  - out_valid = FIFO non-empty.
  - out_left and out_right are registered and must hold stable while out_valid=1 and out_ready=0.
  - A pop occurs on out_valid & out_ready.
  - A push and a pop in the same cycle when full is allowed: no drop, occupancy unchanged.
  - A push when full with no pop drops the new pair, keeps the stored data, and sets overflow.
  - Empty with out_ready=1: no action.
  - Read and write pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- Flags:
  - overflow and frame_err stay set until clear_flags.
  - If clear_flags coincides with a new set event, set wins.

Optional Feature:
- Macro: AUDIO_ADC_MONO_MIX_EN
- Defined:
  - Each pushed pair is replaced by mono = (sign_ext(L) + sign_ext(R)) >>> 1, computed at SAMPLE_W+1 bits with an arithmetic shift and truncated to SAMPLE_W bits.
  - out_left = out_right = mono.
  - Push latency grows by one cycle for a registered adder.
- Undefined: raw L and R are passed through; no adder is present.

Test Plan:
- Frame with SAMPLE_W=16 and 32 BCLKs per channel, L=0x1234, R=0xABCD -> exactly one pair, out_left=0x1234, out_right=0xABCD; flags stay 0.
- Stimulus starting mid-right-channel, followed by a full frame with L=0x0001, R=0x0002 -> the partial right word is discarded and the only output is 0x0001/0x0002.
- out_ready held 0 across 5 frames with FIFO_DEPTH=4 -> 4 pairs are held in order, overflow=1, the 5th pair is absent; clear_flags -> overflow=0.
- LRCK toggling after only 12 bits of L=0xFFF -> out_left=0xFFF0 and frame_err=1; the next full frame is correct.
- reset_reset_n asserted mid-SHIFT with 2 pairs buffered -> out_valid=0 immediately; after release no output appears until a new LRCK 1->0 edge plus a complete pair.
- With AUDIO_ADC_MONO_MIX_EN defined: L=0x7FFF, R=0x0001 -> 0x4000 on both outputs; L=0x8000, R=0x8000 -> 0x8000; L=0xFFFF, R=0x0000 -> 0xFFFF.

Source files
------------

// File: rtl/audio_adc_deserializer.sv
// Audio codec ADC front end: synchronizes the I2S serial lines (ADCDAT, ADCLRCK,
// BCLK) into clk_clk, deserializes left/right words, buffers stereo pairs in a
// small FIFO and presents them on a valid/ready stream.
// Optional feature: define AUDIO_ADC_MONO_MIX_EN to replace each pair with the
// averaged mono sample on both outputs (adds one registered adder stage).
module audio_adc_deserializer #(
  parameter int SAMPLE_W    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                audio_interface_ADCDAT,
  input  logic                audio_interface_ADCLRCK,
  input  logic                audio_interface_BCLK,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                clear_flags,
  output logic                overflow,
  output logic                frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_W + 1);

  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, HOLD} state_t;

  logic [SYNC_STAGES-1:0] dat_sync, lrck_sync, bclk_sync;
  logic                   dat_s, lrck_s, bclk_s, bclk_d, lrck_prev;
  logic                   rise, lrck_edge;

  state_t                 state;
  logic                   chan;
  logic [CW-1:0]          cnt;
  logic [SAMPLE_W-1:0]    shreg;
  logic [CW:0]            shamt;
  logic [SAMPLE_W-1:0]    full_word, short_word, latch_word;
  logic                   latch_en;

  logic [SAMPLE_W-1:0]    l_hold, r_hold;
  logic                   l_pending, pair_rdy;

  logic                   push_vld;
  logic [SAMPLE_W-1:0]    push_l, push_r;

  logic [SAMPLE_W-1:0]    mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]            wptr, rptr;
  logic                   empty, full, pop, push_ok;

  // Synchronizer chains for the three asynchronous codec inputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dat_sync  <= '0;
      lrck_sync <= '0;
      bclk_sync <= '0;
      bclk_d    <= 1'b0;
    end else begin
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0],  audio_interface_ADCDAT};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], audio_interface_ADCLRCK};
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], audio_interface_BCLK};
      bclk_d    <= bclk_s;
    end
  end

  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign rise      = bclk_s & ~bclk_d;
  assign lrck_edge = rise & (lrck_s != lrck_prev);

  // Word completion: full word includes the current bit; a short word is
  // left-aligned so the missing LSBs come out as zero
  always_comb begin
    shamt      = (CW + 1)'(SAMPLE_W) - {1'b0, cnt};
    full_word  = {shreg[SAMPLE_W-2:0], dat_s};
    short_word = shreg << shamt;
    latch_en   = rise && (state == SHIFT) && (lrck_edge || (cnt == CW'(SAMPLE_W - 1)));
    latch_word = lrck_edge ? short_word : full_word;
  end

  // Frame FSM: tracks channel, I2S one-bit delay, bit count and frame errors
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= SYNC;
      chan      <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      lrck_prev <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clear_flags) frame_err <= 1'b0;
      if (rise) begin
        lrck_prev <= lrck_s;
        case (state)
          SYNC: begin
            if (lrck_edge && !lrck_s) begin
              state <= DELAY;
              chan  <= 1'b0;
            end
          end
          DELAY: begin
            if (lrck_edge) begin
              chan <= ~chan;
            end else begin
              state <= SHIFT;
              cnt   <= '0;
              shreg <= '0;
            end
          end
          SHIFT: begin
            if (lrck_edge) begin
              frame_err <= 1'b1;
              chan      <= ~chan;
              state     <= DELAY;
            end else begin
              shreg <= full_word;
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(SAMPLE_W - 1)) state <= HOLD;
            end
          end
          HOLD: begin
            if (lrck_edge) begin
              chan  <= ~chan;
              state <= DELAY;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  // Pair assembly: an R word only forms a pair if an L word is pending
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      l_hold    <= '0;
      r_hold    <= '0;
      l_pending <= 1'b0;
      pair_rdy  <= 1'b0;
    end else begin
      pair_rdy <= 1'b0;
      if (latch_en) begin
        if (!chan) begin
          l_hold    <= latch_word;
          l_pending <= 1'b1;
        end else if (l_pending) begin
          r_hold    <= latch_word;
          pair_rdy  <= 1'b1;
          l_pending <= 1'b0;
        end
      end
    end
  end

`ifdef AUDIO_ADC_MONO_MIX_EN
  logic signed [SAMPLE_W:0] mix_sum;

  assign mix_sum = $signed({l_hold[SAMPLE_W-1], l_hold}) + $signed({r_hold[SAMPLE_W-1], r_hold});

  // Registered mono mix: average at SAMPLE_W+1 bits, arithmetic shift, truncate
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      push_vld <= 1'b0;
      push_l   <= '0;
      push_r   <= '0;
    end else begin
      push_vld <= pair_rdy;
      push_l   <= SAMPLE_W'(mix_sum >>> 1);
      push_r   <= SAMPLE_W'(mix_sum >>> 1);
    end
  end
`else
  // Raw pair pass-through to the FIFO write port
  always_comb begin
    push_vld = pair_rdy;
    push_l   = l_hold;
    push_r   = r_hold;
  end
`endif

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = out_valid & out_ready;
  // Push into a full FIFO is still accepted when the head is popped the same cycle
  assign push_ok = push_vld & (~full | pop);

  assign out_valid = ~empty;
  assign out_left  = mem_l[rptr[AW-1:0]];
  assign out_right = mem_r[rptr[AW-1:0]];

  // FIFO storage, pointers and sticky overflow flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_l[wptr[AW-1:0]] <= push_l;
        mem_r[wptr[AW-1:0]] <= push_r;
        wptr <= wptr + (AW + 1)'(1);
      end
      if (pop) rptr <= rptr + (AW + 1)'(1);
      if (clear_flags) overflow <= 1'b0;
      if (push_vld && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Scoreboard bench for audio_adc_deserializer: expected pairs are queued when a
// frame is issued; a monitor pops and compares on every accepted output.
module tb_audio_adc_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_dat = 1'b0;
  logic        adc_lrck = 1'b0;
  logic        bclk = 1'b0;
  logic [15:0] out_left, out_right;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic        overflow, frame_err;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_l [$];
  logic [15:0] exp_r [$];

  audio_adc_deserializer #(
    .SAMPLE_W   (16),
    .FIFO_DEPTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_clk                (clk),
    .reset_reset_n          (rst_n),
    .audio_interface_ADCDAT (adc_dat),
    .audio_interface_ADCLRCK(adc_lrck),
    .audio_interface_BCLK   (bclk),
    .out_left               (out_left),
    .out_right              (out_right),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .clear_flags            (clear_flags),
    .overflow               (overflow),
    .frame_err              (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] mono(input logic [15:0] l, input logic [15:0] r);
    logic [16:0] s;
    s = {l[15], l} + {r[15], r};
    return s[16:1];
  endfunction

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDIO_ADC_MONO_MIX_EN
    exp_l.push_back(mono(l, r));
    exp_r.push_back(mono(l, r));
`else
    exp_l.push_back(l);
    exp_r.push_back(r);
`endif
  endtask

  // One BCLK period (8 clk_clk cycles): data and LRCK change while BCLK is low
  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0; adc_lrck = lr; adc_dat = d;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // Channel slot: edge bit, I2S delay bit, nbits of val MSB-first, zero padding
  task automatic send_chan(input logic lr, input logic [31:0] val, input int nbits, input int total);
    logic [31:0] v;
    v = val;
    for (int i = 0; i < total; i++) begin
      if (i >= 2 && i < 2 + nbits) send_bit(lr, v[nbits - 1 - (i - 2)]);
      else send_bit(lr, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_chan(1'b0, {16'h0, l}, 16, 32);
    send_chan(1'b1, {16'h0, r}, 16, 32);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bclk = 1'b0; adc_lrck = 1'b0; adc_dat = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_l.size() != 0; i++) @(posedge clk);
    chk(name, exp_l.size(), 0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
  endtask

  // Monitor: every accepted pair must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_l.size() == 0) begin
        chk("unexpected_pair", {out_left, out_right}, 32'hxxxxxxxx);
      end else begin
        chk("pair", {out_left, out_right}, {exp_l.pop_front(), exp_r.pop_front()});
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_left", out_left, 0);
    chk("rst_right", out_right, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);

    // Basic frame plus mono-mix boundary vectors
    out_ready = 1'b1;
    send_chan(1'b1, 0, 0, 4);
    push_exp(16'h1234, 16'hABCD);
    send_frame(16'h1234, 16'hABCD);
    wait_drain("drain_basic");
    chk("basic_overflow", overflow, 0);
    chk("basic_frame_err", frame_err, 0);
    push_exp(16'h7FFF, 16'h0001); send_frame(16'h7FFF, 16'h0001);
    push_exp(16'h8000, 16'h8000); send_frame(16'h8000, 16'h8000);
    push_exp(16'hFFFF, 16'h0000); send_frame(16'hFFFF, 16'h0000);
    wait_drain("drain_mix");

    // Start mid-right: partial word discarded
    do_reset();
    send_chan(1'b1, 32'hBEEF, 16, 20);
    push_exp(16'h0001, 16'h0002);
    send_frame(16'h0001, 16'h0002);
    wait_drain("drain_midright");

    // Back-pressure: 5 frames into a depth-4 FIFO
    do_reset();
    out_ready = 1'b0;
    send_chan(1'b1, 0, 0, 4);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) push_exp(16'h1111 * k[15:0], 16'h2222 * k[15:0]);
      send_frame(16'h1111 * k[15:0], 16'h2222 * k[15:0]);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_head_stable", {out_left, out_right}, {exp_l[0], exp_r[0]});
    pulse_clear();
    #1 chk("ovf_cleared", overflow, 0);
    out_ready = 1'b1;
    wait_drain("drain_ovf");
    repeat (5) @(posedge clk);
    #1 chk("ovf_empty_after", out_valid, 0);

    // Short left word: 12 ones -> 0xFFF0 and frame_err
    do_reset();
    send_chan(1'b1, 0, 0, 4);
    push_exp(16'hFFF0, 16'h00AA);
    send_chan(1'b0, 32'hFFF, 12, 14);
    send_chan(1'b1, 32'h00AA, 16, 32);
    wait_drain("drain_short");
    chk("short_frame_err", frame_err, 1);
    push_exp(16'h1357, 16'h2468);
    send_frame(16'h1357, 16'h2468);
    wait_drain("drain_after_short");
    chk("short_frame_err_sticky", frame_err, 1);
    pulse_clear();
    #1 chk("frame_err_cleared", frame_err, 0);

    // Reset mid-SHIFT with two pairs buffered
    do_reset();
    out_ready = 1'b0;
    send_chan(1'b1, 0, 0, 4);
    send_frame(16'hAAAA, 16'h5555);
    send_frame(16'hCCCC, 16'h3333);
    send_chan(1'b0, 32'h1111, 16, 10);
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1 chk("reset_valid_immediate", out_valid, 0);
    chk("reset_left_zero", out_left, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send_chan(1'b0, 0, 0, 22);
    send_chan(1'b1, 32'h7777, 16, 32);
    chk("post_reset_no_output", out_valid, 0);
    push_exp(16'h0F0F, 16'hF0F0);
    send_frame(16'h0F0F, 16'hF0F0);
    wait_drain("drain_post_reset");
    chk("post_reset_overflow", overflow, 0);

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
